// File: rtl/preadd_mult_combined.sv
// Two-stage pre-add + multiply: dual 18-bit lanes (mode 0) or one 27-bit lane (mode 1).
// Define PREADD_COMBINED_PREADDER_EN to enable the pre-adder; otherwise a bypasses it.
module preadd_mult_combined (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        mode,
  input  logic        in_valid,
  input  logic [36:0] a,
  input  logic [36:0] b,
  input  logic [35:0] c,
  output logic [37:0] preadd_out,
  output logic [73:0] product,
  output logic        out_valid
);

  logic [35:0] a_q;
  logic [35:0] c_q;
  logic        mode_q;
  logic        v_q;

  logic [18:0] s1, s2;
  logic [27:0] s;
  logic [36:0] p1, p2;
  logic [54:0] p;
  logic [37:0] pre_d;
  logic [73:0] prod_d;

`ifdef PREADD_COMBINED_PREADDER_EN
  logic [35:0] b_q;
  logic        unused;
  assign unused = ^{a[36], b[36]};

  always_ff @(posedge clk) begin
    if (reset) b_q <= '0;
    else if (ce) b_q <= b[35:0];
  end

  assign s1 = {1'b0, a_q[17:0]} + {1'b0, b_q[17:0]};
  assign s2 = {1'b0, a_q[35:18]} + {1'b0, b_q[35:18]};
  assign s  = {1'b0, a_q[26:0]} + {1'b0, b_q[26:0]};
`else
  logic unused;
  assign unused = ^{a[36], b};

  assign s1 = {1'b0, a_q[17:0]};
  assign s2 = {1'b0, a_q[35:18]};
  assign s  = {1'b0, a_q[26:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      c_q    <= '0;
      mode_q <= 1'b0;
      v_q    <= 1'b0;
    end else if (ce) begin
      a_q    <= a[35:0];
      c_q    <= c;
      mode_q <= mode;
      v_q    <= in_valid;
    end
  end

  // Lanes are multiplied separately so no carry can cross between them.
  assign p1 = {18'b0, s1} * {19'b0, c_q[17:0]};
  assign p2 = {18'b0, s2} * {19'b0, c_q[35:18]};
  assign p  = {27'b0, s} * {28'b0, c_q[26:0]};

  assign pre_d  = mode_q ? {10'b0, s} : {s2, s1};
  assign prod_d = mode_q ? {19'b0, p} : {p2, p1};

  always_ff @(posedge clk) begin
    if (reset) begin
      preadd_out <= '0;
      product    <= '0;
      out_valid  <= 1'b0;
    end else if (ce) begin
      preadd_out <= pre_d;
      product    <= prod_d;
      out_valid  <= v_q;
    end
  end

endmodule

// File: tb/tb_preadd_mult_combined.sv
// Randomized bench for preadd_mult_combined against a plain-arithmetic model.
// Model follows the PREADD_COMBINED_PREADDER_EN setting of the build.
module tb_preadd_mult_combined;

  logic        clk = 1'b0;
  logic        reset, ce, mode, in_valid;
  logic [36:0] a, b;
  logic [35:0] c;
  logic [37:0] preadd_out;
  logic [73:0] product;
  logic        out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [37:0] pre;
    logic [73:0] prod;
    logic        v;
  } res_t;

  res_t q[$];
  res_t cur;

  always #5 clk = ~clk;

  preadd_mult_combined dut (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode),
    .in_valid(in_valid), .a(a), .b(b), .c(c),
    .preadd_out(preadd_out), .product(product),
    .out_valid(out_valid)
  );

  task automatic check(input string tag,
                       input logic [73:0] got,
                       input logic [73:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic m, input logic v,
                                 input logic [36:0] av,
                                 input logic [36:0] bv,
                                 input logic [35:0] cv);
    res_t r;
    longint unsigned alo, ahi, blo, bhi, a27, b27;
    longint unsigned s1, s2, s, p1, p2, p;
    alo = av & 37'h3FFFF;
    ahi = (av >> 18) & 37'h3FFFF;
    a27 = av & 37'h7FFFFFF;
`ifdef PREADD_COMBINED_PREADDER_EN
    blo = bv & 37'h3FFFF;
    bhi = (bv >> 18) & 37'h3FFFF;
    b27 = bv & 37'h7FFFFFF;
`else
    blo = 0; bhi = 0; b27 = 0;
`endif
    r.v = v;
    if (!m) begin
      s1 = alo + blo;
      s2 = ahi + bhi;
      p1 = s1 * (cv & 36'h3FFFF);
      p2 = s2 * ((cv >> 18) & 36'h3FFFF);
      r.pre  = (38'(s2) << 19) | 38'(s1);
      r.prod = (74'(p2) << 37) | 74'(p1);
    end else begin
      s = a27 + b27;
      p = s * (cv & 36'h7FFFFFF);
      r.pre  = 38'(s);
      r.prod = 74'(p);
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic e, input logic m,
                      input logic v, input logic [36:0] av,
                      input logic [36:0] bv, input logic [35:0] cv);
    res_t z;
    reset = r; ce = e; mode = m; in_valid = v;
    a = av; b = bv; c = cv;
    @(posedge clk);
    if (r) begin
      z = '{pre: '0, prod: '0, v: 1'b0};
      q.delete();
      q.push_back(z);
      cur = z;
    end else if (e) begin
      q.push_back(model(m, v, av, bv, cv));
      cur = q.pop_front();
    end
    #1;
    check("preadd_out", 74'(preadd_out), 74'(cur.pre));
    check("product", product, cur.prod);
    check("out_valid", 74'(out_valid), 74'(cur.v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, '0, '0);
  endtask

  logic [36:0] ra, rb;
  logic [35:0] rc;

  initial begin
    reset = 1; ce = 0; mode = 0; in_valid = 0;
    a = '0; b = '0; c = '0;
    step(1, 0, 0, 0, '0, '0, '0);
    step(1, 1, 0, 0, '0, '0, '0);

    // lane example
    step(0, 1, 0, 1, {1'b0, 18'd100, 18'd3},
         {1'b0, 18'd28, 18'd4}, {18'd2, 18'd5});
    idle(2);
    // wide example
    step(0, 1, 1, 1, 37'd100000, 37'd23456, 36'd1000);
    idle(2);
    // maximum lanes, upper bits set to check they are ignored
    step(0, 1, 0, 1, '1, '1, '1);
    idle(2);
    step(0, 1, 1, 1, 37'h7FFFFFF, 37'h7FFFFFF, 36'h7FFFFFF);
    step(0, 1, 1, 1, '1, '1, '1);
    idle(2);

    // alternate modes then stall
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      step(0, 1, i[0], 1, ra, rb, rc);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, '1, '1, '1);
    idle(2);

    // reset with data in flight
    step(0, 1, 0, 1, '1, '1, '1);
    step(0, 1, 1, 1, '1, '1, '1);
    step(1, 1, 0, 1, '1, '1, '1);
    idle(2);
    step(0, 1, 0, 1, {$urandom, $urandom}, {$urandom, $urandom},
         {$urandom, $urandom});
    idle(2);

    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
           1'($urandom), 1'($urandom), ra, rb, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
